cmsdk_ahb_slave_mux_defslv: RTL and testbench

AHB-Lite data-phase response multiplexer with an integrated default slave. Sits directly downstream of the MCU address decoder. It consumes the per-slave HSEL vector and the default-slave select, registers them at the end of each address phase, and returns the selected slave's HRDATA/HREADYOUT/HRESP to the CPU as HRDATA/HREADY/HRESP. Unmapped NONSEQ/SEQ accesses receive the standard two-cycle AHB ERROR response.

---
 rtl/cmsdk_ahb_slave_mux_defslv_if.sv | 34 +++
 rtl/cmsdk_ahb_slave_mux_defslv.sv | 142 ++++++++++++++
 tb/tb_cmsdk_ahb_slave_mux_defslv.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmsdk_ahb_slave_mux_defslv_if.sv
`default_nettype none
// ============================================================================
// Module      : cmsdk_ahb_slave_mux_defslv_if
// Description : Bus bundle between the CPU/decoder/slaves side (master) and
//               the data-phase response multiplexer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface cmsdk_ahb_slave_mux_defslv_if #(
   parameter int NUM_SLAVES = 9,
   parameter int DATA_W     = 32
) ();
   logic [NUM_SLAVES-1:0]        hsel_vec;
   logic                         defslv_hsel;
   logic [1:0]                   HTRANS;
   logic [NUM_SLAVES-1:0]        hreadyout_vec;
   logic [NUM_SLAVES-1:0]        hresp_vec;
   logic [NUM_SLAVES*DATA_W-1:0] hrdata_bus;
   logic                         HREADY;
   logic                         HRESP;
   logic [DATA_W-1:0]            HRDATA;

   // Decoder, CPU and slave side: drives selects and slave responses
   modport master (
      output hsel_vec, defslv_hsel, HTRANS, hreadyout_vec, hresp_vec, hrdata_bus,
      input  HREADY, HRESP, HRDATA
   );

   // Response multiplexer side
   modport slave (
      input  hsel_vec, defslv_hsel, HTRANS, hreadyout_vec, hresp_vec, hrdata_bus,
      output HREADY, HRESP, HRDATA
   );
endinterface
`default_nettype wire

// File: rtl/cmsdk_ahb_slave_mux_defslv.sv
`default_nettype none
// ============================================================================
// Module      : cmsdk_ahb_slave_mux_defslv
// Description : AHB-Lite data-phase response multiplexer with an integrated
//               default slave returning a two-cycle ERROR to unmapped
//               NONSEQ/SEQ accesses.
//               Optional macro CMSDK_AHB_SLAVE_MUX_ERRCNT_EN adds a saturating
//               unmapped-access counter (err_count) with clear (err_clr).
// Revision    : 1.0 - initial release
// ============================================================================
module cmsdk_ahb_slave_mux_defslv #(
   parameter int NUM_SLAVES = 9,
   parameter int DATA_W     = 32
) (
   input  wire                         HCLK,
   input  wire                         HRESET,
`ifdef CMSDK_AHB_SLAVE_MUX_ERRCNT_EN
   input  wire                         err_clr,
   output logic [15:0]                 err_count,
`endif
   cmsdk_ahb_slave_mux_defslv_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ERR1 = 2'd1,
      S_ERR2 = 2'd2
   } state_t;

   localparam logic [NUM_SLAVES-1:0] c_one = NUM_SLAVES'(1);

   logic [NUM_SLAVES-1:0] w_hsel_first;
   logic                  w_any_hsel;
   logic                  w_def_req;
   logic [NUM_SLAVES-1:0] r_dsel;
   logic                  r_ddef;
   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_fsm_hready;
   logic                  w_fsm_hresp;
   logic                  w_slv_hready;
   logic                  w_slv_hresp;
   logic [DATA_W-1:0]     w_slv_hrdata;
   logic                  w_hready;
   logic                  w_unused_htrans;

   // Isolate the lowest set select bit so a non-one-hot decoder output still
   // registers a single slave.
   assign w_hsel_first    = bus.hsel_vec & ((~bus.hsel_vec) + c_one);
   assign w_any_hsel      = |bus.hsel_vec;
   assign w_def_req       = bus.defslv_hsel & bus.HTRANS[1] & ~w_any_hsel;
   assign w_unused_htrans = bus.HTRANS[0];

   // Address-phase select capture, held while the current data phase stalls
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_dsel <= '0;
         r_ddef <= 1'b0;
      end else if (w_hready) begin
         r_dsel <= w_hsel_first;
         r_ddef <= w_def_req;
      end
   end

   // Default-slave state register
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Default-slave next state and response. In IDLE the default slave owns no
   // data phase, so the bus ready seen there is the real-slave path.
   always_comb begin
      w_state_nxt  = r_state;
      w_fsm_hready = 1'b1;
      w_fsm_hresp  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_slv_hready && w_def_req) begin
               w_state_nxt = S_ERR1;
            end
         end
         S_ERR1: begin
            w_fsm_hready = 1'b0;
            w_fsm_hresp  = 1'b1;
            w_state_nxt  = S_ERR2;
         end
         S_ERR2: begin
            w_fsm_hresp = 1'b1;
            w_state_nxt = w_def_req ? S_ERR1 : S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Real-slave response mux; with nothing selected it yields a zero-wait OKAY
   always_comb begin
      w_slv_hready = 1'b1;
      w_slv_hresp  = 1'b0;
      w_slv_hrdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (r_dsel[i]) begin
            w_slv_hready = bus.hreadyout_vec[i];
            w_slv_hresp  = bus.hresp_vec[i];
            w_slv_hrdata = bus.hrdata_bus[i*DATA_W +: DATA_W];
         end
      end
   end

   assign w_hready   = r_ddef ? w_fsm_hready : w_slv_hready;
   assign bus.HREADY = w_hready;
   assign bus.HRESP  = r_ddef ? w_fsm_hresp : w_slv_hresp;
   assign bus.HRDATA = r_ddef ? '0 : w_slv_hrdata;

`ifdef CMSDK_AHB_SLAVE_MUX_ERRCNT_EN
   logic [15:0] r_err_count;
   logic        w_err_inc;

   // ERR1 is only ever entered from IDLE or ERR2, i.e. once per new error
   assign w_err_inc = (w_state_nxt == S_ERR1);

   // Saturating unmapped-access counter; clear beats a coincident increment
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_err_count <= '0;
      end else if (err_clr) begin
         r_err_count <= '0;
      end else if (w_err_inc && (r_err_count != 16'hFFFF)) begin
         r_err_count <= r_err_count + 16'd1;
      end
   end

   assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmsdk_ahb_slave_mux_defslv.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmsdk_ahb_slave_mux_defslv
// Description : Self-checking bench for cmsdk_ahb_slave_mux_defslv using a
//               transaction-level reference model of the data phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmsdk_ahb_slave_mux_defslv;

   localparam int NS = 9;
   localparam int DW = 32;

   logic clk     = 1'b0;
   logic rst     = 1'b1;
   logic err_clr = 1'b0;

   always #5 clk = ~clk;

   cmsdk_ahb_slave_mux_defslv_if #(.NUM_SLAVES(NS), .DATA_W(DW)) bus ();

`ifdef CMSDK_AHB_SLAVE_MUX_ERRCNT_EN
   logic [15:0] err_count;
`endif

   cmsdk_ahb_slave_mux_defslv #(.NUM_SLAVES(NS), .DATA_W(DW)) dut (
      .HCLK     (clk),
      .HRESET   (rst),
`ifdef CMSDK_AHB_SLAVE_MUX_ERRCNT_EN
      .err_clr  (err_clr),
      .err_count(err_count),
`endif
      .bus      (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: what owns the current data phase.
   // m_kind: -1 nothing, -2 default slave (m_phase 0/1 = first/second cycle),
   // >=0 index of the real slave.
   int m_kind  = -1;
   int m_phase = 0;
   int m_cnt   = 0;

   logic [DW+1:0] exp_o;
   wire  [DW+1:0] got_o = {bus.HREADY, bus.HRESP, bus.HRDATA};

   function automatic logic [DW+1:0] model_out();
      logic [DW+1:0] r;
      if (m_kind == -2) begin
         r = {(m_phase == 1), 1'b1, {DW{1'b0}}};
      end else if (m_kind >= 0) begin
         r = {bus.hreadyout_vec[m_kind], bus.hresp_vec[m_kind],
              bus.hrdata_bus[m_kind*DW +: DW]};
      end else begin
         r = {1'b1, 1'b0, {DW{1'b0}}};
      end
      return r;
   endfunction

   // One clock edge; the model advances from the pre-edge inputs
   task automatic tick();
      logic [DW+1:0] e;
      int            nk;
      bit            inc;
      e   = model_out();
      inc = 1'b0;
      @(posedge clk);
      if (rst) begin
         m_kind  = -1;
         m_phase = 0;
         m_cnt   = 0;
      end else begin
         if (e[DW+1]) begin
            nk = -1;
            for (int i = NS-1; i >= 0; i--) if (bus.hsel_vec[i]) nk = i;
            if (nk < 0 && bus.defslv_hsel && bus.HTRANS[1]) nk = -2;
            m_kind  = nk;
            m_phase = 0;
            inc     = (nk == -2);
         end else if (m_kind == -2) begin
            m_phase = 1;
         end
         if (err_clr) m_cnt = 0;
         else if (inc && m_cnt < 65535) m_cnt++;
      end
      #1;
   endtask

   task automatic drive_idle();
      bus.hsel_vec      = '0;
      bus.defslv_hsel   = 1'b0;
      bus.HTRANS        = 2'b00;
      bus.hreadyout_vec = '1;
      bus.hresp_vec     = '0;
      for (int i = 0; i < NS; i++) bus.hrdata_bus[i*DW +: DW] = $urandom;
      err_clr = 1'b0;
   endtask

   task automatic do_reset();
      drive_idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if (got_o !== {1'b1, 1'b0, {DW{1'b0}}}) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected %h", got_o, {1'b1, 1'b0, {DW{1'b0}}});
      end
`ifdef CMSDK_AHB_SLAVE_MUX_ERRCNT_EN
      checks++;
      if (err_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_errcnt: got %0d expected 0", err_count);
      end
`endif
   endtask

   task automatic test_slave_read();
      drive_idle();
      bus.hsel_vec             = NS'(1) << 1;
      bus.HTRANS               = 2'b10;
      bus.hrdata_bus[DW +: DW] = 32'h2000_1234;
      tick();
      bus.hsel_vec = '0;
      bus.HTRANS   = 2'b00;
      #1;
      checks++;
      if (got_o !== {1'b1, 1'b0, 32'h2000_1234}) begin
         errors++;
         $display("FAIL slave1_read: got %h expected %h", got_o, {1'b1, 1'b0, 32'h2000_1234});
      end
      tick();
   endtask

   task automatic test_wait_states();
      drive_idle();
      bus.hsel_vec = NS'(1) << 3;
      bus.HTRANS   = 2'b10;
      tick();
      bus.hsel_vec         = NS'(1);
      bus.hreadyout_vec[3] = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #1;
         exp_o = model_out();
         checks++;
         if (got_o !== exp_o || bus.HREADY !== 1'b0) begin
            errors++;
            $display("FAIL wait_stall%0d: got %h expected %h", c, got_o, exp_o);
         end
         tick();
      end
      bus.hreadyout_vec[3] = 1'b1;
      #1;
      exp_o = model_out();
      checks++;
      if (got_o !== exp_o || bus.HRDATA !== bus.hrdata_bus[3*DW +: DW]) begin
         errors++;
         $display("FAIL wait_release: got %h expected %h", got_o, exp_o);
      end
      tick();
      bus.hsel_vec = '0;
      bus.HTRANS   = 2'b00;
      #1;
      checks++;
      if (bus.HRDATA !== bus.hrdata_bus[0 +: DW] || got_o !== model_out()) begin
         errors++;
         $display("FAIL wait_next_slave0: got %h expected %h", got_o, model_out());
      end
      tick();
   endtask

   task automatic test_default_error();
      logic [DW+1:0] seq [3];
      seq[0] = {1'b0, 1'b1, {DW{1'b0}}};
      seq[1] = {1'b1, 1'b1, {DW{1'b0}}};
      seq[2] = {1'b1, 1'b0, {DW{1'b0}}};
      drive_idle();
      bus.defslv_hsel = 1'b1;
      bus.HTRANS      = 2'b10;
      tick();
      bus.defslv_hsel = 1'b0;
      bus.HTRANS      = 2'b00;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (got_o !== seq[c] || got_o !== model_out()) begin
            errors++;
            $display("FAIL default_err_cycle%0d: got %h expected %h", c, got_o, seq[c]);
         end
         tick();
      end
   endtask

   task automatic test_default_idle();
      logic [1:0] tr [2];
      tr[0] = 2'b00;
      tr[1] = 2'b01;
      for (int k = 0; k < 2; k++) begin
         drive_idle();
         bus.defslv_hsel = 1'b1;
         bus.HTRANS      = tr[k];
         tick();
         drive_idle();
         #1;
         checks++;
         if (got_o !== {1'b1, 1'b0, {DW{1'b0}}}) begin
            errors++;
            $display("FAIL default_no_err_htrans%0d: got %h expected %h", tr[k], got_o,
                     {1'b1, 1'b0, {DW{1'b0}}});
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] rr [4];
      rr[0] = 2'b01;
      rr[1] = 2'b11;
      rr[2] = 2'b01;
      rr[3] = 2'b11;
      do_reset();
      bus.defslv_hsel = 1'b1;
      bus.HTRANS      = 2'b10;
      tick();
      for (int c = 0; c < 4; c++) begin
         if (c == 2) begin
            bus.defslv_hsel = 1'b0;
            bus.HTRANS      = 2'b00;
         end
         #1;
         checks++;
         if ({bus.HREADY, bus.HRESP} !== rr[c] || got_o !== model_out()) begin
            errors++;
            $display("FAIL b2b_cycle%0d: got %h expected %h", c, got_o, model_out());
         end
         if (c < 3) tick();
      end
`ifdef CMSDK_AHB_SLAVE_MUX_ERRCNT_EN
      checks++;
      if (err_count !== 16'd2 || m_cnt != 2) begin
         errors++;
         $display("FAIL b2b_errcnt: got %0d expected 2", err_count);
      end
`endif
      bus.defslv_hsel = 1'b1;
      bus.HTRANS      = 2'b10;
      err_clr         = 1'b1;
      tick();
      err_clr         = 1'b0;
      bus.defslv_hsel = 1'b0;
      bus.HTRANS      = 2'b00;
      #1;
      checks++;
      if (got_o !== {1'b0, 1'b1, {DW{1'b0}}}) begin
         errors++;
         $display("FAIL b2b_third_err1: got %h expected %h", got_o, {1'b0, 1'b1, {DW{1'b0}}});
      end
`ifdef CMSDK_AHB_SLAVE_MUX_ERRCNT_EN
      checks++;
      if (err_count !== 16'd0) begin
         errors++;
         $display("FAIL b2b_clear_wins: got %0d expected 0", err_count);
      end
`endif
      tick();
      tick();
   endtask

   task automatic test_reset_in_err1();
      do_reset();
      bus.defslv_hsel = 1'b1;
      bus.HTRANS      = 2'b10;
      tick();
      #1;
      checks++;
      if (got_o !== {1'b0, 1'b1, {DW{1'b0}}}) begin
         errors++;
         $display("FAIL rst_err1_entry: got %h expected %h", got_o, {1'b0, 1'b1, {DW{1'b0}}});
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive_idle();
      #1;
      checks++;
      if (got_o !== {1'b1, 1'b0, {DW{1'b0}}}) begin
         errors++;
         $display("FAIL rst_err1_abandon: got %h expected %h", got_o, {1'b1, 1'b0, {DW{1'b0}}});
      end
      tick();
   endtask

   task automatic test_random();
      int mode;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         mode = $urandom_range(0, 9);
         if (mode < 4)      bus.hsel_vec = '0;
         else if (mode < 8) bus.hsel_vec = NS'(1) << $urandom_range(0, NS-1);
         else               bus.hsel_vec = NS'($urandom);
         bus.defslv_hsel = ($urandom_range(0, 2) != 0);
         bus.HTRANS      = 2'($urandom);
         for (int i = 0; i < NS; i++) begin
            bus.hreadyout_vec[i]     = ($urandom_range(0, 3) != 0);
            bus.hresp_vec[i]         = ($urandom_range(0, 7) == 0);
            bus.hrdata_bus[i*DW +: DW] = $urandom;
         end
         err_clr = ($urandom_range(0, 15) == 0);
         rst     = ($urandom_range(0, 59) == 0);
         #1;
         exp_o = model_out();
         checks++;
         if (got_o !== exp_o) begin
            errors++;
            $display("FAIL random_cycle%0d: got %h expected %h", n, got_o, exp_o);
         end
`ifdef CMSDK_AHB_SLAVE_MUX_ERRCNT_EN
         checks++;
         if (err_count !== 16'(m_cnt)) begin
            errors++;
            $display("FAIL random_errcnt%0d: got %0d expected %0d", n, err_count, m_cnt);
         end
`endif
         tick();
      end
      rst = 1'b0;
      drive_idle();
      tick();
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_slave_read();
      test_wait_states();
      test_default_error();
      test_default_idle();
      test_back_to_back();
      test_reset_in_err1();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
